ifetch_unit: RTL



---
 rtl/ifetch_unit.sv | 139 +++++++++++++
 1 files changed

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - instruction fetch unit with a 2-entry decode queue
module ifetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [63:0] pc_addr,
    input  logic [31:0] instruction,
    input  logic        imem_exc_en,
    input  logic [3:0]  imem_exc_code,
    input  logic [63:0] imem_exc_val,
    input  logic        redirect_en,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [63:0] out_pc,
    output logic        out_exc_en,
    output logic [3:0]  out_exc_code,
    output logic [63:0] out_exc_val
);

    typedef enum logic {
        FETCH = 1'b0,
        HALT  = 1'b1
    } state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [1:0]  FULL_CNT  = 2'(QDEPTH);

    state_e      state_q;
    logic [63:0] fetch_pc_q;
    logic [1:0]  count_q;
    logic        rd_ptr_q;
    logic        wr_ptr_q;

    logic [31:0] q_instr_q [2];
    logic [63:0] q_pc_q    [2];
    logic        q_exc_en_q[2];
    logic [3:0]  q_code_q  [2];
    logic [63:0] q_val_q   [2];

    logic        pop;
    logic        push;
    logic        misaligned;
    logic [31:0] new_instr;
    logic        new_exc_en;
    logic [3:0]  new_code;
    logic [63:0] new_val;
    logic [1:0]  count_d;

    assign pc_addr    = fetch_pc_q;
    assign out_valid  = (count_q != 2'd0);
    assign pop        = out_valid && out_ready;
    assign misaligned = (fetch_pc_q[1:0] != 2'b00);
    assign push       = (state_q == FETCH) && !redirect_en
                        && ((count_q != FULL_CNT) || pop);

    // A misaligned PC never reaches memory semantics: its response is discarded.
    always_comb begin
        new_instr  = instruction;
        new_exc_en = imem_exc_en;
        new_code   = imem_exc_code;
        new_val    = imem_exc_val;
        if (misaligned) begin
            new_instr  = NOP_INSTR;
            new_exc_en = 1'b1;
            new_code   = 4'd0;
            new_val    = fetch_pc_q;
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= FETCH;
            fetch_pc_q <= RESET_PC;
            count_q    <= 2'd0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
        end else if (redirect_en) begin
            state_q    <= FETCH;
            fetch_pc_q <= redirect_pc;
            count_q    <= 2'd0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            if (push) begin
                wr_ptr_q <= ~wr_ptr_q;
                // Faulting PC is held so the halt state keeps presenting it.
                if (new_exc_en) begin
                    state_q <= HALT;
                end else begin
                    fetch_pc_q <= fetch_pc_q + 64'd4;
                end
            end
        end
    end

    // Storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk) begin
        if (push) begin
            q_instr_q[wr_ptr_q]  <= new_instr;
            q_pc_q[wr_ptr_q]     <= fetch_pc_q;
            q_exc_en_q[wr_ptr_q] <= new_exc_en;
            q_code_q[wr_ptr_q]   <= new_code;
            q_val_q[wr_ptr_q]    <= new_val;
        end
    end

    always_comb begin
        out_instr    = NOP_INSTR;
        out_pc       = 64'd0;
        out_exc_en   = 1'b0;
        out_exc_code = 4'd0;
        out_exc_val  = 64'd0;
        if (out_valid) begin
            out_instr    = q_instr_q[rd_ptr_q];
            out_pc       = q_pc_q[rd_ptr_q];
            out_exc_en   = q_exc_en_q[rd_ptr_q];
            out_exc_code = q_code_q[rd_ptr_q];
            out_exc_val  = q_val_q[rd_ptr_q];
        end
    end

endmodule
